// File: rtl/pc_gen.sv
// pc_gen: fetch-PC generator with a direct-mapped BTB, boot bubble and ID redirects.
// Optional macro PC_GEN_PERF_EN adds 64-bit fetch / taken-fetch / redirect counters.
module pc_gen #(
  parameter int              PC_W      = 64,
  parameter logic [PC_W-1:0] RESET_PC  = 64'h8000_0000,
  parameter int              BTB_IDX_W = 4,
  parameter int              BTB_TAG_W = 16
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] pc,
  output logic            valid_pre,
  input  logic            pred_jump,
  input  logic            if_ready,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            id_redirect,
  input  logic [PC_W-1:0] id_redirect_pc,
  input  logic            id_btb_wr,
  input  logic [PC_W-1:0] id_btb_pc,
  input  logic [PC_W-1:0] id_btb_target
`ifdef PC_GEN_PERF_EN
  ,
  output logic [63:0]     perf_fetch,
  output logic [63:0]     perf_pred_taken,
  output logic [63:0]     perf_redirect
`endif
);
  localparam int NE     = 1 << BTB_IDX_W;
  localparam int TAG_LO = BTB_IDX_W + 2;
  localparam int TAG_HI = TAG_LO + BTB_TAG_W - 1;

  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t                 state_q;
  logic                   valid_q;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [NE-1:0]          btb_v_q, btb_v_d;
  logic [BTB_TAG_W-1:0]   btb_tag_q [NE];
  logic [PC_W-3:0]        btb_tgt_q [NE];
  logic [BTB_IDX_W-1:0]   idx, wr_idx;
  logic                   hit;
  logic                   unused;

  assign pc        = pc_q;
  assign valid_pre = valid_q;
  assign idx       = pc_q[BTB_IDX_W+1:2];
  assign wr_idx    = id_btb_pc[BTB_IDX_W+1:2];
  assign unused    = ^{id_btb_pc[PC_W-1:TAG_HI+1], id_btb_pc[1:0], id_btb_target[1:0]};

  // BTB lookup, prediction and next-PC selection (redirect beats the handshake)
  always_comb begin
    hit         = btb_v_q[idx] && btb_tag_q[idx] == pc_q[TAG_HI:TAG_LO];
    pred_taken  = valid_q && pred_jump && hit;
    pred_target = pred_taken ? {btb_tgt_q[idx], 2'b00} : pc_q + PC_W'(4);
    pc_d        = id_redirect ? id_redirect_pc : (valid_q && if_ready) ? pred_target : pc_q;
    btb_v_d     = btb_v_q | (id_btb_wr ? NE'(1) << wr_idx : '0);
  end

  // Boot FSM: one bubble cycle after reset so the predictor table can clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      valid_q <= 1'b0;
    end else begin
      state_q <= S_RUN;
      valid_q <= 1'b1;
    end
  end

  // Fetch PC and BTB valid bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      btb_v_q <= '0;
    end else begin
      pc_q    <= pc_d;
      btb_v_q <= btb_v_d;
    end
  end

  // BTB tag/target payload; entries are gated by the valid bits so need no reset
  always_ff @(posedge clock) begin
    if (id_btb_wr) begin
      btb_tag_q[wr_idx] <= id_btb_pc[TAG_HI:TAG_LO];
      btb_tgt_q[wr_idx] <= id_btb_target[PC_W-1:2];
    end
  end

`ifdef PC_GEN_PERF_EN
  logic [63:0] perf_fetch_q, perf_fetch_d;
  logic [63:0] perf_taken_q, perf_taken_d;
  logic [63:0] perf_redir_q, perf_redir_d;

  assign perf_fetch      = perf_fetch_q;
  assign perf_pred_taken = perf_taken_q;
  assign perf_redirect   = perf_redir_q;

  // Event counters, wrapping at 2^64
  always_comb begin
    perf_fetch_d = perf_fetch_q + 64'(valid_q && if_ready);
    perf_taken_d = perf_taken_q + 64'(valid_q && if_ready && pred_taken);
    perf_redir_d = perf_redir_q + 64'(id_redirect);
  end

  // Counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_taken_q <= '0;
      perf_redir_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_taken_q <= perf_taken_d;
      perf_redir_q <= perf_redir_d;
    end
  end
`endif
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test-plan sequence plus randomized traffic against a behavioural model.
module tb_pc_gen;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clock = 0;
  logic        reset = 0;
  logic [63:0] pc;
  logic        valid_pre;
  logic        pred_jump = 0;
  logic        if_ready = 0;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        id_redirect = 0;
  logic [63:0] id_redirect_pc = '0;
  logic        id_btb_wr = 0;
  logic [63:0] id_btb_pc = '0;
  logic [63:0] id_btb_target = '0;
`ifdef PC_GEN_PERF_EN
  logic [63:0] perf_fetch, perf_pred_taken, perf_redirect;
`endif

  pc_gen dut (
    .clock(clock), .reset(reset), .pc(pc), .valid_pre(valid_pre),
    .pred_jump(pred_jump), .if_ready(if_ready), .pred_taken(pred_taken),
    .pred_target(pred_target), .id_redirect(id_redirect), .id_redirect_pc(id_redirect_pc),
    .id_btb_wr(id_btb_wr), .id_btb_pc(id_btb_pc), .id_btb_target(id_btb_target)
`ifdef PC_GEN_PERF_EN
    , .perf_fetch(perf_fetch), .perf_pred_taken(perf_pred_taken), .perf_redirect(perf_redirect)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // behavioural model: BTB remembers the full written PC, tag match is done arithmetically
  logic [63:0] m_pc;
  bit          m_valid;
  bit          m_bv [16];
  logic [63:0] m_bpc [16];
  logic [63:0] m_btgt [16];
  logic [63:0] m_fetch, m_taken_cnt, m_redir;

  task automatic m_reset();
    m_pc = RST_PC;
    m_valid = 0;
    foreach (m_bv[i]) m_bv[i] = 0;
    m_fetch = 0;
    m_taken_cnt = 0;
    m_redir = 0;
  endtask

  function automatic int idx_of(input logic [63:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] a);
    return (a / 64) % 65536;
  endfunction

  task automatic step(input bit j, input bit r, input bit rd, input logic [63:0] rpc,
                      input bit w, input logic [63:0] wpc, input logic [63:0] wt);
    int i;
    bit hit, tk;
    logic [63:0] tgt;
    pred_jump = j; if_ready = r; id_redirect = rd; id_redirect_pc = rpc;
    id_btb_wr = w; id_btb_pc = wpc; id_btb_target = wt;
    #1;
    i = idx_of(m_pc);
    hit = m_bv[i] && tag_of(m_bpc[i]) == tag_of(m_pc);
    tk = m_valid && j && hit;
    tgt = tk ? m_btgt[i] - (m_btgt[i] % 4) : m_pc + 4;
    check("pc", pc, m_pc);
    check("valid_pre", 64'(valid_pre), 64'(m_valid));
    check("pred_taken", 64'(pred_taken), 64'(tk));
    check("pred_target", pred_target, tgt);
`ifdef PC_GEN_PERF_EN
    check("perf_fetch", perf_fetch, m_fetch);
    check("perf_pred_taken", perf_pred_taken, m_taken_cnt);
    check("perf_redirect", perf_redirect, m_redir);
`endif
    if (m_valid && r) m_fetch++;
    if (m_valid && r && tk) m_taken_cnt++;
    if (rd) m_redir++;
    m_pc = rd ? rpc : (m_valid && r) ? tgt : m_pc;
    m_valid = 1;
    if (w) begin
      m_bv[idx_of(wpc)] = 1;
      m_bpc[idx_of(wpc)] = wpc;
      m_btgt[idx_of(wpc)] = wt;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic async_reset();
    reset = 0;
    #1;
    m_reset();
    check("rst_pc", pc, RST_PC);
    check("rst_valid_pre", 64'(valid_pre), 64'd0);
    check("rst_pred_taken", 64'(pred_taken), 64'd0);
    check("rst_pred_target", pred_target, RST_PC + 4);
    @(posedge clock);
    @(negedge clock);
    reset = 1;
  endtask

  function automatic logic [63:0] rnd_pc();
    logic [63:0] a;
    a = RST_PC + 64'($urandom_range(0, 31)) * 4;
    if ($urandom_range(0, 7) == 0) a = a | 64'h1_0000;
    return a;
  endfunction

  initial begin
    m_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("plan_seq_pc8", pc, 64'h8000_0008);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    check("plan_stall_hold", pc, 64'h8000_0008);
    step(0, 1, 0, 0, 0, 0, 0);
    check("plan_resume", pc, 64'h8000_000C);
    step(0, 1, 0, 0, 1, 64'h8000_0010, 64'h8000_0100);
    check("plan_taken_flag", 64'(pred_jump | 1'b1) & 64'(0) | 64'(pc == 64'h8000_0010), 64'd1);
    step(1, 1, 0, 0, 0, 0, 0);
    check("plan_taken_pc", pc, 64'h8000_0100);
    step(0, 1, 1, 64'h8000_0010, 0, 0, 0);
    pred_jump = 0; if_ready = 1; #1;
    check("plan_nt_target", pred_target, 64'h8000_0014);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 64'h8001_0010, 0, 0, 0);
    pred_jump = 1; #1;
    check("plan_alias_taken", 64'(pred_taken), 64'd0);
    step(1, 1, 0, 0, 0, 0, 0);
    check("plan_alias_pc", pc, 64'h8001_0014);
    step(0, 1, 1, 64'h8000_0010, 0, 0, 0);
    step(1, 1, 1, 64'h8000_0200, 0, 0, 0);
    check("plan_redirect_pc", pc, 64'h8000_0200);
    step(0, 1, 1, 64'h8000_0104, 0, 0, 0);
    async_reset();
    step(0, 1, 1, 64'h8000_0010, 0, 0, 0);
    pred_jump = 1; #1;
    check("plan_btb_cleared", 64'(pred_taken), 64'd0);
    step(1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                rnd_pc(), $urandom_range(0, 3) == 0, rnd_pc(), rnd_pc() | 64'($urandom_range(0, 3)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Fetch-PC generator; sits directly upstream of the direction predictor.
- Holds the architectural fetch PC and drives it with `valid_pre` to the predictor and to IF.
- Combines the predictor's `jump` with an internal direct-mapped BTB to select the next PC.
- Accepts mispredict/jump redirects and BTB updates from ID.

Parameters:
- PC_W, 64, fetch PC width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.
- BTB_IDX_W, 4, log2 of BTB entries (16).
- BTB_TAG_W, 16, tag bits taken from pc[BTB_IDX_W+2+BTB_TAG_W-1 : BTB_IDX_W+2].

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pc  out  PC_W  current fetch PC (to predictor `pc` and IF)
- valid_pre  out  1  pc valid this cycle (to predictor `valid_pre` and IF)
- pred_jump  in  1  predictor `jump` for pc, same cycle
- if_ready  in  1  IF accepts pc this cycle
- pred_taken  out  1  pc predicted taken (travels with the instruction)
- pred_target  out  PC_W  predicted next PC for pc (taken target or pc+4)
- id_redirect  in  1  ID correction request
- id_redirect_pc  in  PC_W  corrected PC
- id_btb_wr  in  1  ID resolved a taken jump/branch
- id_btb_pc  in  PC_W  PC of that jump
- id_btb_target  in  PC_W  its resolved target

Behaviour:
- Async reset (reset==0): pc=RESET_PC, state=S_BOOT, valid_pre=0, pred_taken=0, pred_target=RESET_PC+4, all BTB valid bits=0.
- FSM S_BOOT:
  - valid_pre=0 for exactly one cycle after reset release; this gives the predictor's synchronous table reset time to complete.
  - Next state is S_RUN.
  - id_redirect in S_BOOT loads id_redirect_pc and still goes to S_RUN.
- FSM S_RUN:
  - valid_pre=1 continuously.
  - No other states.
- BTB lookup (combinational on pc):
  - idx = pc[BTB_IDX_W+1:2].
  - hit = valid[idx] && tag[idx]==pc tag field.
- Prediction:
  - pred_taken = valid_pre && pred_jump && hit.
  - pred_target = pred_taken ? {target[idx][PC_W-1:2],2'b00} : pc+4.
  - Arithmetic wraps modulo 2^PC_W.
- PC update, in priority order:
  - (1) id_redirect: pc <= id_redirect_pc, regardless of if_ready. The current pc is discarded; IF must ignore it.
  - (2) valid_pre && if_ready: pc <= pred_target.
  - (3) otherwise pc holds.
- Stall: while if_ready=0, pc, pred_taken and pred_target are stable, provided pred_jump is stable.
- BTB write on id_btb_wr:
  - Entry at idx(id_btb_pc) gets valid=1, tag=tag(id_btb_pc), target=id_btb_target.
  - Overwrite is unconditional; there is no replacement policy.
- Write/read to the same index in the same cycle: the lookup sees the old contents; the new entry is visible next cycle.
- Simultaneous id_redirect and id_btb_wr: both take effect.
- Not-taken resolution never invalidates a BTB entry.
- Latency: redirect to new pc on valid_pre is 1 cycle, with no bubble.

Optional Feature:
- Macro: PC_GEN_PERF_EN.
- Defined: adds outputs perf_fetch, perf_pred_taken and perf_redirect, each 64 bits.
  - They count, respectively: accepted handshakes (valid_pre&&if_ready), accepted handshakes with pred_taken=1, and cycles with id_redirect=1.
  - All reset to 0 and wrap at 2^64.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, if_ready=1, pred_jump=0 -> cycle0 valid_pre=0 pc=0x80000000; then pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles.
- if_ready=0 for 3 cycles at pc=0x80000008 -> pc holds 0x80000008; resumes at 0x8000000C when if_ready=1.
- BTB write pc=0x80000010 target=0x80000100, then fetch 0x80000010 with pred_jump=1 -> pred_taken=1, next pc=0x80000100. With pred_jump=0 -> next pc=0x80000014.
- Aliasing: BTB holds 0x80000010; fetch 0x80010010 (same idx, different tag) with pred_jump=1 -> pred_taken=0, next pc=0x80010014.
- id_redirect=1, id_redirect_pc=0x80000200, same cycle as if_ready=1 and pred_taken=1 -> next pc=0x80000200. The redirect wins; with PC_GEN_PERF_EN, perf_redirect increments by 1.
- Assert reset mid-run at pc=0x80000104 -> pc=0x80000000 and valid_pre=0 immediately (asynchronous). The BTB is cleared, so a fetch of 0x80000010 with pred_jump=1 gives pred_taken=0.
